// File: rtl/fb_pkg.sv
// Shared constants and enums for the framebuffer port arbiter.
package fb_pkg;

  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int X_MAX = 319;
  localparam int Y_MAX = 199;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SKIP,
    ST_WAIT
  } fb_state_e;

  typedef enum logic {
    PORT_V,
    PORT_E
  } fb_port_e;

endpackage

// File: rtl/fb_req_latch.sv
// Per-requester pending register: captures one access while idle, reports
// ready and flags pulses that arrive while an access is still outstanding.
module fb_req_latch #(
  parameter int XW = fb_pkg::X_W,
  parameter int YW = fb_pkg::Y_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  input  logic          req_read,
  input  logic          req_write,
  input  logic          req_in,
  input  logic          done,
  output logic          pending,
  output logic [XW-1:0] lat_x,
  output logic [YW-1:0] lat_y,
  output logic          lat_write,
  output logic          lat_in,
  output logic          rdy,
  output logic          ovf
);

  logic          pending_q, pending_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          write_q, write_d;
  logic          in_q, in_d;
  logic          req_any;

  assign req_any = req_read | req_write;

  // done and a new capture are mutually exclusive: capture needs pending low
  always_comb begin
    pending_d = pending_q;
    x_d       = x_q;
    y_d       = y_q;
    write_d   = write_q;
    in_d      = in_q;
    if (done) begin
      pending_d = 1'b0;
    end
    if (req_any && !pending_q) begin
      pending_d = 1'b1;
      x_d       = req_x;
      y_d       = req_y;
      write_d   = req_write;
      in_d      = req_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      write_q   <= 1'b0;
      in_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      x_q       <= x_d;
      y_q       <= y_d;
      write_q   <= write_d;
      in_q      <= in_d;
    end
  end

  assign pending   = pending_q;
  assign lat_x     = x_q;
  assign lat_y     = y_q;
  assign lat_write = write_q;
  assign lat_in    = in_q;
  assign rdy       = ~pending_q;
  assign ovf       = req_any & pending_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the framebuffer port between scanout (V, priority) and the blit
// engine (E), with a bounded V streak so E always makes progress.
module fb_port_arbiter #(
  parameter int X_W      = fb_pkg::X_W,
  parameter int Y_W      = fb_pkg::Y_W,
  parameter int V_STREAK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] v_x,
  input  logic [Y_W-1:0] v_y,
  input  logic           v_read,
  output logic           v_rdy,
  output logic           v_out,
  input  logic [X_W-1:0] e_x,
  input  logic [Y_W-1:0] e_y,
  input  logic           e_read,
  input  logic           e_write,
  input  logic           e_in,
  output logic           e_rdy,
  output logic           e_out,
  output logic [X_W-1:0] m_x,
  output logic [Y_W-1:0] m_y,
  output logic           m_read,
  output logic           m_write,
  output logic           m_in,
  input  logic           m_out,
  input  logic           m_rdy,
  output logic           err_ovf
);

  import fb_pkg::*;

  localparam int             SW         = $clog2(V_STREAK + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(V_STREAK);

  logic           v_pend, v_lat_write, v_lat_in, v_ovf, v_done;
  logic [X_W-1:0] v_lat_x;
  logic [Y_W-1:0] v_lat_y;
  logic           e_pend, e_lat_write, e_lat_in, e_ovf, e_done;
  logic [X_W-1:0] e_lat_x;
  logic [Y_W-1:0] e_lat_y;

  fb_req_latch #(.XW(X_W), .YW(Y_W)) u_v_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_x     (v_x),
    .req_y     (v_y),
    .req_read  (v_read),
    .req_write (1'b0),
    .req_in    (1'b0),
    .done      (v_done),
    .pending   (v_pend),
    .lat_x     (v_lat_x),
    .lat_y     (v_lat_y),
    .lat_write (v_lat_write),
    .lat_in    (v_lat_in),
    .rdy       (v_rdy),
    .ovf       (v_ovf)
  );

  fb_req_latch #(.XW(X_W), .YW(Y_W)) u_e_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_x     (e_x),
    .req_y     (e_y),
    .req_read  (e_read),
    .req_write (e_write),
    .req_in    (e_in),
    .done      (e_done),
    .pending   (e_pend),
    .lat_x     (e_lat_x),
    .lat_y     (e_lat_y),
    .lat_write (e_lat_write),
    .lat_in    (e_lat_in),
    .rdy       (e_rdy),
    .ovf       (e_ovf)
  );

  fb_state_e      state_q, state_d;
  fb_port_e       win_q, win_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic           settle_q, settle_d;
  logic           op_write_q, op_write_d;
  logic [X_W-1:0] m_x_q, m_x_d;
  logic [Y_W-1:0] m_y_q, m_y_d;
  logic           m_in_q, m_in_d;
  logic           m_read_q, m_read_d;
  logic           m_write_q, m_write_d;
  logic           v_out_q, v_out_d;
  logic           e_out_q, e_out_d;
  logic           err_ovf_q, err_ovf_d;
  logic           grant_v;
  logic           sel_write;

  // settle_q skips arbitration for the cycle in which a port's rdy rises, so a
  // requester re-pulsing on that rdy still competes in the next arbitration.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    streak_d   = streak_q;
    settle_d   = settle_q;
    op_write_d = op_write_q;
    m_x_d      = m_x_q;
    m_y_d      = m_y_q;
    m_in_d     = m_in_q;
    m_read_d   = 1'b0;
    m_write_d  = 1'b0;
    v_out_d    = v_out_q;
    e_out_d    = e_out_q;
    err_ovf_d  = err_ovf_q | v_ovf | e_ovf;
    v_done     = 1'b0;
    e_done     = 1'b0;
    grant_v    = v_pend && (!e_pend || (streak_q < STREAK_MAX));
    sel_write  = grant_v ? v_lat_write : e_lat_write;

    case (state_q)
      ST_IDLE: begin
        settle_d = 1'b0;
        if (!settle_q && (v_pend || e_pend)) begin
          win_d      = grant_v ? PORT_V : PORT_E;
          m_x_d      = grant_v ? v_lat_x : e_lat_x;
          m_y_d      = grant_v ? v_lat_y : e_lat_y;
          m_in_d     = grant_v ? v_lat_in : e_lat_in;
          op_write_d = sel_write;
          m_read_d   = !sel_write;
          m_write_d  = sel_write;
          // a V grant over a pending E only happens below the limit, so +1 saturates
          if (!grant_v) begin
            streak_d = '0;
          end else if (e_pend) begin
            streak_d = streak_q + 1'b1;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_SKIP;
      ST_SKIP:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (m_rdy) begin
          if (win_q == PORT_V) begin
            v_done = 1'b1;
            if (!op_write_q) v_out_d = m_out;
          end else begin
            e_done = 1'b1;
            if (!op_write_q) e_out_d = m_out;
          end
          settle_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= PORT_V;
      streak_q   <= '0;
      settle_q   <= 1'b0;
      op_write_q <= 1'b0;
      m_x_q      <= '0;
      m_y_q      <= '0;
      m_in_q     <= 1'b0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      v_out_q    <= 1'b0;
      e_out_q    <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      streak_q   <= streak_d;
      settle_q   <= settle_d;
      op_write_q <= op_write_d;
      m_x_q      <= m_x_d;
      m_y_q      <= m_y_d;
      m_in_q     <= m_in_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      v_out_q    <= v_out_d;
      e_out_q    <= e_out_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  assign m_x     = m_x_q;
  assign m_y     = m_y_q;
  assign m_in    = m_in_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign v_out   = v_out_q;
  assign e_out   = e_out_q;
  assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural framebuffer model.
module tb_fb_port_arbiter;
  import fb_pkg::*;

  localparam int V_STREAK = 4;

  logic           clk, rst_n;
  logic [X_W-1:0] v_x, e_x, m_x;
  logic [Y_W-1:0] v_y, e_y, m_y;
  logic           v_read, v_rdy, v_out;
  logic           e_read, e_write, e_in, e_rdy, e_out;
  logic           m_read, m_write, m_in, m_out, m_rdy, err_ovf;

  fb_port_arbiter #(.X_W(X_W), .Y_W(Y_W), .V_STREAK(V_STREAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .v_x(v_x), .v_y(v_y), .v_read(v_read), .v_rdy(v_rdy), .v_out(v_out),
    .e_x(e_x), .e_y(e_y), .e_read(e_read), .e_write(e_write), .e_in(e_in),
    .e_rdy(e_rdy), .e_out(e_out),
    .m_x(m_x), .m_y(m_y), .m_read(m_read), .m_write(m_write), .m_in(m_in),
    .m_out(m_out), .m_rdy(m_rdy), .err_ovf(err_ovf)
  );

  typedef struct {
    logic           rd;
    logic           wr;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           d;
    logic           exp_out;
  } vec_t;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           wr;
    logic           d;
  } pulse_t;

  vec_t   vecs [13];
  pulse_t log_q [$];
  bit     mem [0:X_MAX][0:Y_MAX];
  int     fb_lat = 1;
  int     fb_cnt;
  logic   rd_bit;
  int     tests = 0;
  int     failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer model: m_rdy drops after a pulse and returns fb_lat cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy  <= 1'b1;
      m_out  <= 1'b0;
      fb_cnt <= 0;
      rd_bit <= 1'b0;
    end else if (m_write) begin
      mem[m_x][m_y] <= m_in;
      m_rdy  <= 1'b0;
      fb_cnt <= fb_lat;
    end else if (m_read) begin
      rd_bit <= mem[m_x][m_y];
      m_rdy  <= 1'b0;
      fb_cnt <= fb_lat;
    end else if (fb_cnt > 1) begin
      fb_cnt <= fb_cnt - 1;
    end else if (fb_cnt == 1) begin
      fb_cnt <= 0;
      m_rdy  <= 1'b1;
      m_out  <= rd_bit;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (m_read || m_write)) log_q.push_back('{m_x, m_y, m_write, m_in});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vr, input logic [X_W-1:0] vx, input logic [Y_W-1:0] vy,
                               input logic er, input logic ew, input logic [X_W-1:0] ex,
                               input logic [Y_W-1:0] ey, input logic ein);
    @(negedge clk);
    v_read = vr; v_x = vx; v_y = vy;
    e_read = er; e_write = ew; e_x = ex; e_y = ey; e_in = ein;
    @(negedge clk);
    v_read = 1'b0; e_read = 1'b0; e_write = 1'b0;
  endtask

  // Called in the cycle after a pulse; returns the cycle index at which rdy is high
  task automatic waitRdy(input bit on_e, output int cyc);
    cyc = 1;
    while (((on_e ? e_rdy : v_rdy) !== 1'b1) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(on_e ? "e_rdy returns" : "v_rdy returns", on_e ? e_rdy : v_rdy, 1);
  endtask

  task automatic runStreak();
    int   base, first_e, cyc;
    logic prev;
    base = log_q.size();
    applyStimulus(1'b1, 9'd1, 8'd1, 1'b1, 1'b0, 9'd7, 8'd7, 1'b0);
    prev = v_rdy;
    cyc  = 0;
    while (e_rdy !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      v_read = 1'b0;
      if (v_rdy && !prev && !e_rdy) begin
        v_x = 9'd1; v_y = 8'd1; v_read = 1'b1;
      end
      prev = v_rdy;
    end
    checkOutput("streak e_rdy returns", e_rdy, 1);
    waitRdy(1'b0, cyc);
    first_e = -1;
    for (int i = base; i < log_q.size(); i++) begin
      if (first_e < 0 && log_q[i].x == 9'd7) first_e = i - base;
    end
    checkOutput("V grants before E", first_e, V_STREAK);
    checkOutput("grants in round", log_q.size() - base, V_STREAK + 2);
    if (log_q.size() >= base + 6) checkOutput("V after E", log_q[base+5].x, 1);
  endtask

  initial begin
    int base, cyc;
    vecs[0]  = '{1'b0, 1'b1, 9'd10, 8'd20, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 9'd10, 8'd20, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, X_W'(X_MAX), Y_W'(Y_MAX), 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, X_W'(X_MAX), Y_W'(Y_MAX), 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 9'd0, 8'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 9'd0, 8'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 9'd10, 8'd20, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 9'd10, 8'd20, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 9'd10, 8'd20, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 9'd10, 8'd20, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 9'd20, 8'd30, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 9'd20, 8'd30, 1'b0, 1'b1};

    rst_n = 1'b0;
    v_read = 1'b0; v_x = '0; v_y = '0;
    e_read = 1'b0; e_write = 1'b0; e_in = 1'b0; e_x = '0; e_y = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset v_rdy", v_rdy, 1);
    checkOutput("reset e_rdy", e_rdy, 1);
    checkOutput("reset v_out", v_out, 0);
    checkOutput("reset e_out", e_out, 0);
    checkOutput("reset m_read", m_read, 0);
    checkOutput("reset m_write", m_write, 0);
    checkOutput("reset m_x", m_x, 0);
    checkOutput("reset m_y", m_y, 0);
    checkOutput("reset m_in", m_in, 0);
    checkOutput("reset err_ovf", err_ovf, 0);
    rst_n = 1'b1;

    // Single-port E accesses, one at a time, with an immediate framebuffer
    for (int i = 0; i < 13; i++) begin
      base = log_q.size();
      applyStimulus(1'b0, '0, '0, vecs[i].rd, vecs[i].wr, vecs[i].x, vecs[i].y, vecs[i].d);
      checkOutput("e_rdy low after pulse", e_rdy, 0);
      waitRdy(1'b1, cyc);
      checkOutput("E latency", cyc, 5);
      checkOutput("E pulse count", log_q.size() - base, 1);
      if (log_q.size() > base) begin
        checkOutput("E m_x", log_q[base].x, vecs[i].x);
        checkOutput("E m_y", log_q[base].y, vecs[i].y);
        checkOutput("E op is write", log_q[base].wr, vecs[i].wr);
        if (vecs[i].wr) checkOutput("E m_in", log_q[base].d, vecs[i].d);
      end
      checkOutput("E e_out", e_out, vecs[i].exp_out);
    end

    base = log_q.size();
    applyStimulus(1'b1, 9'd10, 8'd20, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("v_rdy low after pulse", v_rdy, 0);
    waitRdy(1'b0, cyc);
    checkOutput("V latency", cyc, 5);
    checkOutput("V readback v_out", v_out, 1);
    checkOutput("V pulse count", log_q.size() - base, 1);

    // Same-cycle V read and E write
    base = log_q.size();
    applyStimulus(1'b1, 9'd0, 8'd0, 1'b0, 1'b1, 9'd5, 8'd5, 1'b1);
    waitRdy(1'b0, cyc);
    waitRdy(1'b1, cyc);
    checkOutput("same-cycle pulse count", log_q.size() - base, 2);
    if (log_q.size() >= base + 2) begin
      checkOutput("same-cycle first is V read", {log_q[base].wr, log_q[base].x}, {1'b0, 9'd0});
      checkOutput("same-cycle second is E write", {log_q[base+1].wr, log_q[base+1].x, log_q[base+1].d},
                  {1'b1, 9'd5, 1'b1});
    end
    checkOutput("same-cycle v_out", v_out, 1);

    // Starvation bound, twice: the second round only repeats if the streak cleared
    runStreak();
    runStreak();

    // Overflow: a second e_read while e_rdy is low
    checkOutput("err_ovf before overflow", err_ovf, 0);
    base = log_q.size();
    @(negedge clk);
    e_read = 1'b1; e_x = 9'd2; e_y = 8'd2;
    @(negedge clk);
    checkOutput("ovf e_rdy low", e_rdy, 0);
    e_x = 9'd3; e_y = 8'd3;
    @(negedge clk);
    e_read = 1'b0;
    waitRdy(1'b1, cyc);
    checkOutput("ovf pulse count", log_q.size() - base, 1);
    if (log_q.size() > base) checkOutput("ovf served addr", log_q[base].x, 2);
    checkOutput("err_ovf set", err_ovf, 1);
    repeat (5) @(negedge clk);
    checkOutput("err_ovf sticky", err_ovf, 1);

    // Reset during WAIT with a slow framebuffer
    fb_lat = 8;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 9'd4, 8'd4, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("pre-reset m_x held", m_x, 4);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset v_rdy", v_rdy, 1);
    checkOutput("midreset e_rdy", e_rdy, 1);
    checkOutput("midreset v_out", v_out, 0);
    checkOutput("midreset e_out", e_out, 0);
    checkOutput("midreset m_read", m_read, 0);
    checkOutput("midreset m_write", m_write, 0);
    checkOutput("midreset m_x", m_x, 0);
    checkOutput("midreset m_y", m_y, 0);
    checkOutput("midreset m_in", m_in, 0);
    checkOutput("midreset err_ovf", err_ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fb_lat = 1;
    base = log_q.size();
    repeat (10) @(negedge clk);
    checkOutput("no pulse after reset", log_q.size() - base, 0);
    checkOutput("e_rdy after reset", e_rdy, 1);

    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 9'd10, 8'd20, 1'b0);
    waitRdy(1'b1, cyc);
    checkOutput("post-reset latency", cyc, 5);
    checkOutput("post-reset e_out", e_out, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-bit framebuffer access port between two requesters: video scanout on port V (read-only, priority) and the blit/fill engine on port E (read/write).
- Each requester sees the same pulse/ready protocol the framebuffer itself offers, so the engine connects unchanged.
- Sits between the engine, the scanout reader and the framebuffer memory controller.
- Bounded-priority scheduling guarantees the engine forward progress under continuous scanout traffic.

Parameters:
X_W, 9, pixel x coordinate width (0..319)
Y_W, 8, pixel y coordinate width (0..199)
V_STREAK, 4, max consecutive V grants while E is pending before E must be granted

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
v_x  in  X_W  scanout pixel x, sampled with v_read
v_y  in  Y_W  scanout pixel y
v_read  in  1  one-cycle read request pulse
v_rdy  out  1  high = V idle or result valid; low while V request outstanding
v_out  out  1  pixel read for V, valid while v_rdy high after a completion
e_x  in  X_W  engine pixel x, sampled with e_read/e_write
e_y  in  Y_W  engine pixel y
e_read  in  1  one-cycle read pulse
e_write  in  1  one-cycle write pulse
e_in  in  1  write data, sampled with e_write
e_rdy  out  1  as v_rdy, for E
e_out  out  1  pixel read for E
m_x  out  X_W  framebuffer address x
m_y  out  Y_W  framebuffer address y
m_read  out  1  one-cycle read pulse to framebuffer
m_write  out  1  one-cycle write pulse to framebuffer
m_in  out  1  write data to framebuffer
m_out  in  1  read data from framebuffer, valid when m_rdy high after a read
m_rdy  in  1  framebuffer ready; low from cycle after pulse until done
err_ovf  out  1  sticky: a request arrived on a port whose rdy was low

Behaviour:
- Reset (async, rst_n low):
  - v_rdy=1, e_rdy=1; v_out=0, e_out=0.
  - m_read=0, m_write=0, m_x=0, m_y=0, m_in=0.
  - err_ovf=0, streak=0, pending latches cleared, FSM=IDLE.
  - Reset mid-operation abandons the transaction; the framebuffer is reset by the same rst_n.
- Request capture, per port:
  - A pulse sampled while that port's rdy=1 latches address, op and data into the port's pending register.
  - rdy drops to 0 on the next cycle (registered, 1-cycle latency), so a requester that polls rdy two cycles after its pulse sees it low.
  - e_read and e_write together: treat as write.
  - A pulse while rdy=0: ignored, err_ovf set (sticky until reset).
- FSM states: IDLE, ISSUE, SKIP, WAIT.
  - IDLE: if any pending, choose a winner and go to ISSUE.
    - V wins if V pending and (E not pending or streak < V_STREAK).
    - Otherwise E wins if pending.
    - A V grant while E is pending increments streak (saturating at V_STREAK); any E grant clears streak.
  - ISSUE: drive m_x/m_y/m_in from the winner; pulse m_read or m_write for exactly one cycle; go to SKIP.
  - SKIP: m_rdy ignored for one cycle, because the framebuffer lowers m_rdy late; go to WAIT.
  - WAIT: on m_rdy=1:
    - For a read, capture m_out into the winner's v_out/e_out.
    - Clear the winner's pending flag; winner rdy=1 on the next cycle; go to IDLE.
- Address and data hold stable on m_x/m_y/m_in from ISSUE through WAIT.
- Minimum per-access latency, pulse to rdy high: 5 cycles.
- Both ports pulse in the same cycle: both are latched; V is served first unless the streak limit is reached.
- v_out/e_out hold their value until the next completed read on that port; writes leave e_out unchanged.
- No address range checking: the requester clips coordinates.

Decomposition:
- Package fb_pkg:
  - X_W/Y_W constants and the screen limits 319/199.
  - FSM state enum.
  - Port-id enum {PORT_V, PORT_E}.
- Sub-module fb_req_latch, instantiated twice (V with write tied off):
  - Holds pending, address, op and data.
  - Generates rdy and the overflow strobe.
- The arbiter FSM and streak counter stay in the top level.

Test Plan:
- Single E write: e_write pulse with x=10, y=20, e_in=1. Required: one m_write pulse with m_x=10, m_y=20, m_in=1; e_rdy low the next cycle, high 5 cycles after the pulse at the earliest.
- Read-back: E read at (10,20) with a framebuffer model returning 1. Required: e_out=1 when e_rdy rises; a subsequent V read at (10,20) gives v_out=1.
- Same-cycle request: V read (0,0) and E write (5,5) in one cycle. Required: the V m_read issues first, then the E m_write; both rdy signals return high.
- Starvation bound: V re-pulses immediately each time v_rdy rises, with E pending. Required: exactly 4 V grants, then the E grant, then streak resets.
- Overflow: second e_read while e_rdy=0. Required: the request is ignored, exactly one m_* pulse occurs, and err_ovf=1 until reset.
- Reset mid-WAIT: assert rst_n low during WAIT. Required: all outputs take their reset values immediately, with no spurious m pulse after release.
